// File: rtl/lfsr_rng_pkg.sv
`timescale 1ns/1ps
// lfsr_rng_pkg: shared types and constants for the lfsr_rng generator.
//   rng_state_e    - handshake FSM encoding (IDLE / GATHER / READY)
//   LEGAL_WIDTHS   - LFSR widths that have a maximal-length tap set below
//   tap_mask()     - W-bit tap mask (bit i set = tap at 1-based position i+1)
//   is_legal_width - true when w is one of LEGAL_WIDTHS
package lfsr_rng_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    READY  = 2'd2
  } rng_state_e;

  localparam int LEGAL_WIDTHS [4] = '{32'd8, 32'd16, 32'd24, 32'd32};

  // Maximal-length XNOR taps (xapp210), converted from 1-based positions.
  function automatic logic [31:0] tap_mask(input int w);
    logic [31:0] m;
    case (w)
      32'd8:   m = 32'h0000_00B8;  // 8,6,5,4
      32'd16:  m = 32'h0000_D008;  // 16,15,13,4
      32'd24:  m = 32'h00E1_0000;  // 24,23,22,17
      32'd32:  m = 32'h8020_0003;  // 32,22,2,1
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  function automatic logic is_legal_width(input int w);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (LEGAL_WIDTHS[i] == w) begin
        ok = 1'b1;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/lfsr_rng_core.sv
`timescale 1ns/1ps
// lfsr_core: W-bit XNOR Fibonacci LFSR state register.
//   CLK, RST      - clock, asynchronous active-high reset (state <= SEED)
//   EN            - advance one step this cycle
//   LOAD, SEED_IN - synchronous seed load, wins over EN; an all-ones seed
//                   (the XNOR lock-up state) is replaced by SEED
//   state_next    - value the register takes on the next edge, so the
//                   consumer can capture a freshly stepped word in the same
//                   cycle it is produced
module lfsr_core
  import lfsr_rng_pkg::*;
#(
  parameter int          W    = 32,
  parameter logic [31:0] SEED = 32'h6B1C_CA14
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         LOAD,
  input  logic [W-1:0] SEED_IN,
  output logic [W-1:0] state_next
);

  localparam logic [W-1:0] TAPS     = W'(tap_mask(W));
  localparam logic [W-1:0] SEED_W   = SEED[W-1:0];
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  if (!is_legal_width(W)) begin : g_bad_width
    $error("lfsr_core: W must be one of 8, 16, 24, 32");
  end

  logic [W-1:0] state_r;
  logic [W-1:0] next_s;
  logic         fb_s;

  // Feedback and LOAD > step > hold selection of the next state.
  always_comb begin
    fb_s = ~(^(state_r & TAPS));
    if (LOAD) begin
      if (SEED_IN == ALL_ONES) begin
        next_s = SEED_W;
      end else begin
        next_s = SEED_IN;
      end
    end else if (EN) begin
      next_s = {state_r[W-2:0], fb_s};
    end else begin
      next_s = state_r;
    end
  end

  // LFSR state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= SEED_W;
    end else begin
      state_r <= next_s;
    end
  end

  assign state_next = next_s;

endmodule

// File: rtl/lfsr_rng.sv
`timescale 1ns/1ps
// lfsr_rng: LFSR random-word generator with REQ/VALID/ACK handshake.
//   CLK, RST  - clock, asynchronous active-high reset
//   EN        - LFSR step enable (free-runs in every FSM state)
//   LOAD      - seed load; also abandons any pending or unconsumed word
//   SEED_IN   - seed value used by LOAD
//   REQ, ACK  - request a word / accept the presented word
//   RANDOM    - OUT_W-bit word, stable while VALID
//   VALID     - RANDOM holds an unconsumed word (READY)
//   BUSY      - collecting fresh shifts (GATHER)
// Each word is taken after OUT_W counted steps, so successive words never
// share LFSR bits.
module lfsr_rng
  import lfsr_rng_pkg::*;
#(
  parameter int          W     = 32,
  parameter int          OUT_W = 4,
  parameter logic [31:0] SEED  = 32'h6B1C_CA14
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [W-1:0]     SEED_IN,
  input  logic             REQ,
  input  logic             ACK,
  output logic [OUT_W-1:0] RANDOM,
  output logic             VALID,
  output logic             BUSY
);

  localparam int               CNT_W    = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  if (OUT_W < 1 || OUT_W > W) begin : g_bad_out_w
    $error("lfsr_rng: OUT_W must lie in 1..W");
  end

  rng_state_e       state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [OUT_W-1:0] random_r, random_nx_s;
  logic             valid_r, valid_nx_s;
  logic             busy_r, busy_nx_s;
  logic [W-1:0]     lfsr_next_s;

  lfsr_core #(
    .W    (W),
    .SEED (SEED)
  ) u_core (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .LOAD       (LOAD),
    .SEED_IN    (SEED_IN),
    .state_next (lfsr_next_s)
  );

  // FSM, step counter and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      random_r <= '0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      cnt_r    <= cnt_nx_s;
      random_r <= random_nx_s;
      valid_r  <= valid_nx_s;
      busy_r   <= busy_nx_s;
    end
  end

  // Next FSM state, counter and captured word.
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    random_nx_s = random_r;
    if (LOAD) begin
      // A new seed invalidates anything derived from the old sequence;
      // RANDOM itself is left as it was.
      state_nx_s = IDLE;
      cnt_nx_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (REQ) begin
            state_nx_s = GATHER;
            cnt_nx_s   = '0;
          end else begin
            state_nx_s = IDLE;
          end
        end
        GATHER: begin
          if (EN) begin
            if (cnt_r == CNT_LAST) begin
              // This step is the OUT_W-th: take the post-step bits.
              random_nx_s = lfsr_next_s[OUT_W-1:0];
              state_nx_s  = READY;
              cnt_nx_s    = '0;
            end else begin
              cnt_nx_s = cnt_r + CNT_W'(1);
            end
          end else begin
            cnt_nx_s = cnt_r;
          end
        end
        READY: begin
          if (ACK) begin
            state_nx_s = REQ ? GATHER : IDLE;
            cnt_nx_s   = '0;
          end else begin
            state_nx_s = READY;
          end
        end
        default: begin
          state_nx_s = IDLE;
          cnt_nx_s   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so VALID/BUSY come straight from flops.
  always_comb begin
    valid_nx_s = 1'b0;
    busy_nx_s  = 1'b0;
    case (state_nx_s)
      GATHER:  busy_nx_s  = 1'b1;
      READY:   valid_nx_s = 1'b1;
      default: begin
        valid_nx_s = 1'b0;
        busy_nx_s  = 1'b0;
      end
    endcase
  end

  assign RANDOM = random_r;
  assign VALID  = valid_r;
  assign BUSY   = busy_r;

endmodule
